// File: rtl/multi_channel_trigger_ctrl.sv
// multi_channel_trigger_ctrl
//   N-channel trigger controller in the ADC clock domain. Synchronises the raw comparator outputs and
//   the async control levels, and combines the enabled channels (OR or AND) into a trigger. It then
//   applies a programmable holdoff and sequences auto or manual re-arm. It also drives per-channel
//   comparator-reset enables, latches the source channels of each trigger and counts triggers.
// Ports
//   clk_i              ADC clock, all logic on posedge
//   module_reset_ni    synchronous active-low reset
//   trig_in_i          raw comparator outputs (async)
//   ch_enable_i        channel enable mask (quasi-static)
//   combine_and_i      0: OR of enabled channels, 1: AND of enabled channels
//   armed_i            async arm level
//   auto_reset_i       async, 1 = re-arm automatically after holdoff
//   manual_reset_i     async, rising edge re-arms from WAIT_RST
//   manual_trigger_i   async, rising edge forces one trigger pulse
//   holdoff_cycles_i   holdoff length, sampled in FIRE
//   triggered_out_o    one-cycle trigger pulse
//   trig_source_o      enabled channels high at fire, 0 for a manual trigger
//   trig_count_o       triggers issued since reset, wrapping
//   comp_reset_en_o    per-channel comparator reset enable
//   busy_o             high in FIRE/HOLDOFF/WAIT_RST/REARM
module multi_channel_trigger_ctrl #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned HOLDOFF_W   = 16,
    parameter int unsigned RST_PULSE   = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk_i,
    input  logic                 module_reset_ni,
    input  logic [N_CH-1:0]      trig_in_i,
    input  logic [N_CH-1:0]      ch_enable_i,
    input  logic                 combine_and_i,
    input  logic                 armed_i,
    input  logic                 auto_reset_i,
    input  logic                 manual_reset_i,
    input  logic                 manual_trigger_i,
    input  logic [HOLDOFF_W-1:0] holdoff_cycles_i,
    output logic                 triggered_out_o,
    output logic [N_CH-1:0]      trig_source_o,
    output logic [CNT_W-1:0]     trig_count_o,
    output logic [N_CH-1:0]      comp_reset_en_o,
    output logic                 busy_o
);

    localparam int unsigned SyncW  = N_CH + 4;
    localparam int unsigned PulseW = $clog2(RST_PULSE + 1);
    localparam logic [PulseW-1:0] PulseMax = PulseW'(RST_PULSE);

    typedef enum logic [5:0] {
        StDisarmed = 6'b000001,
        StRearm    = 6'b000010,
        StArmed    = 6'b000100,
        StFire     = 6'b001000,
        StHoldoff  = 6'b010000,
        StWaitRst  = 6'b100000
    } state_e;

    // Synchronisers: bit layout {manual_trigger, manual_reset, auto_reset, armed, trig_in}
    logic [SyncW-1:0] async_in;
    logic [SyncW-1:0] sync_q [SYNC_STAGES];
    logic [SyncW-1:0] sync_s;
    // Edge-delay flops only for the signals whose edges matter: {manual_trigger, manual_reset, trig_in}
    logic [N_CH+1:0]  edge_dly_q;

    assign async_in = {manual_trigger_i, manual_reset_i, auto_reset_i, armed_i, trig_in_i};
    assign sync_s   = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (!module_reset_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            edge_dly_q <= '0;
        end else begin
            sync_q[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            edge_dly_q <= {sync_s[N_CH+3:N_CH+2], sync_s[N_CH-1:0]};
        end
    end

    logic [N_CH-1:0] trig_s, trig_rise, trig_en;
    logic            armed_s, auto_s, mreset_rise, mtrig_rise;
    logic            any_rise, all_high, hit, en_high;

    assign trig_s      = sync_s[N_CH-1:0];
    assign armed_s     = sync_s[N_CH];
    assign auto_s      = sync_s[N_CH+1];
    assign trig_rise   = trig_s & ~edge_dly_q[N_CH-1:0];
    assign mreset_rise = sync_s[N_CH+2] & ~edge_dly_q[N_CH];
    assign mtrig_rise  = sync_s[N_CH+3] & ~edge_dly_q[N_CH+1];

    assign trig_en  = trig_s & ch_enable_i;
    assign any_rise = |(trig_rise & ch_enable_i);
    // An empty mask makes any_rise 0, so AND mode cannot fire on it either
    assign all_high = &(trig_s | ~ch_enable_i);
    assign hit      = combine_and_i ? (any_rise & all_high) : any_rise;
    assign en_high  = |trig_en;

    state_e                state_q, state_d;
    logic [HOLDOFF_W-1:0]  hold_q, hold_d;
    logic [PulseW-1:0]     pulse_q, pulse_d;
    logic                  triggered_q, triggered_d;
    logic [N_CH-1:0]       src_q, src_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  man_pend_q, man_pend_d;
    logic                  man_req;

    assign man_req = mtrig_rise | man_pend_q;

    always_comb begin
        state_d         = state_q;
        hold_d          = hold_q;
        pulse_d         = pulse_q;
        triggered_d     = 1'b0;
        src_d           = src_q;
        cnt_d           = cnt_q;
        man_pend_d      = man_pend_q;
        comp_reset_en_o = '0;
        busy_o          = 1'b0;

        unique case (state_q)
            StDisarmed: begin
                if (armed_s) state_d = StRearm;
            end
            StRearm: begin
                busy_o          = 1'b1;
                comp_reset_en_o = trig_en;
                if (!armed_s)      state_d = StDisarmed;
                else if (!en_high) state_d = StArmed;
            end
            StArmed: begin
                if (hit)           state_d = StFire;
                else if (!armed_s) state_d = StDisarmed;
            end
            StFire: begin
                busy_o      = 1'b1;
                triggered_d = 1'b1;
                src_d       = trig_en;
                cnt_d       = cnt_q + 1'b1;
                hold_d      = holdoff_cycles_i;
                pulse_d     = '0;
                state_d     = StHoldoff;
            end
            StHoldoff: begin
                busy_o = 1'b1;
                if (pulse_q < PulseMax) begin
                    comp_reset_en_o = trig_en;
                    pulse_d         = pulse_q + 1'b1;
                end
                if (hold_q == '0) begin
                    if (!armed_s)    state_d = StDisarmed;
                    else if (auto_s) state_d = StRearm;
                    else             state_d = StWaitRst;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            StWaitRst: begin
                busy_o = 1'b1;
                if (!armed_s)         state_d = StDisarmed;
                else if (mreset_rise) state_d = StRearm;
            end
            default: state_d = StDisarmed;
        endcase

        // Manual trigger: merged into FIRE when coincident. It is held back one cycle if a pulse
        // was just issued or a fire is about to happen, so pulses never run back to back.
        if (state_q == StFire) begin
            man_pend_d = 1'b0;
        end else if (triggered_q || (state_q == StArmed && hit)) begin
            man_pend_d = man_req;
        end else if (man_req) begin
            triggered_d = 1'b1;
            src_d       = '0;
            cnt_d       = cnt_q + 1'b1;
            man_pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!module_reset_ni) begin
            state_q     <= StDisarmed;
            hold_q      <= '0;
            pulse_q     <= '0;
            triggered_q <= 1'b0;
            src_q       <= '0;
            cnt_q       <= '0;
            man_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            pulse_q     <= pulse_d;
            triggered_q <= triggered_d;
            src_q       <= src_d;
            cnt_q       <= cnt_d;
            man_pend_q  <= man_pend_d;
        end
    end

    assign triggered_out_o = triggered_q;
    assign trig_source_o   = src_q;
    assign trig_count_o    = cnt_q;

endmodule
